ictrl_noc_to_ibuffer_write: RTL and testbench

ICTRL_NOC_TO_IBUFFER_WRITE -- requirements
Module: ictrl_noc_to_ibuffer_write

---
 rtl/ictrl_noc_to_ibuffer_write.sv | 202 ++++++++++++++++++++
 tb/tb_ictrl_noc_to_ibuffer_write.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ictrl_noc_to_ibuffer_write.sv
`default_nettype none
// ============================================================================
// Module   : ictrl_noc_to_ibuffer_write
// Purpose  : Gathers NoC words into full ibuffer lines (with byte strobes) and
//            writes them through a 2-entry pingpong buffer. Transfers may
//            start on any word lane. Lanes that are not written carry strobe 0.
// Ports    : clk, rst_n            - clock, async active-low reset
//            ibuffer_word_addr/num - transfer start word address / length
//            noc_rd_start/done/busy- transfer control
//            noc_rd_valid/ready/data/last - NoC word stream
//            len_err               - noc_rd_last disagrees with internal count
//            ibuffer_cen/wen/ready/addr/wdata/wstrb - ibuffer write port
// Revision : 1.0 - initial release
// ============================================================================
module ictrl_noc_to_ibuffer_write #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AW     = 15,
  parameter int WORD_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [MEM_AW+$clog2(DATA_WIDTH/WORD_WIDTH)-1:0] ibuffer_word_addr,
  input  logic [12:0]                                    ibuffer_word_num,
  input  logic                                           noc_rd_start,
  output logic                                           noc_rd_done,
  output logic                                           noc_rd_busy,
  input  logic                                           noc_rd_valid,
  output logic                                           noc_rd_ready,
  input  logic [WORD_WIDTH-1:0]                          noc_rd_data,
  input  logic                                           noc_rd_last,
  output logic                                           len_err,
  output logic                                           ibuffer_cen,
  output logic                                           ibuffer_wen,
  input  logic                                           ibuffer_ready,
  output logic [MEM_AW-1:0]                              ibuffer_addr,
  output logic [DATA_WIDTH-1:0]                          ibuffer_wdata,
  output logic [STRB_WIDTH-1:0]                          ibuffer_wstrb
);

  localparam int WORD_NUM = DATA_WIDTH / WORD_WIDTH;
  localparam int WOFF     = $clog2(WORD_NUM);
  localparam int WSTRB    = WORD_WIDTH / 8;
  localparam logic [WOFF-1:0] LAST_LANE = WOFF'(WORD_NUM - 1);

  // Transfer state
  logic                  busy_q, busy_d;
  logic                  zero_len_q, zero_len_d;
  logic [12:0]           word_num_q, word_num_d;
  logic [12:0]           word_cnt_q, word_cnt_d;
  logic [MEM_AW-1:0]     line_addr_q, line_addr_d;
  logic [WOFF-1:0]       word_off_q, word_off_d;
  logic [DATA_WIDTH-1:0] asm_data_q, asm_data_d;
  logic [STRB_WIDTH-1:0] asm_strb_q, asm_strb_d;

  // Pingpong storage
  logic [MEM_AW-1:0]     pp_addr_q [2];
  logic [MEM_AW-1:0]     pp_addr_d [2];
  logic [DATA_WIDTH-1:0] pp_data_q [2];
  logic [DATA_WIDTH-1:0] pp_data_d [2];
  logic [STRB_WIDTH-1:0] pp_strb_q [2];
  logic [STRB_WIDTH-1:0] pp_strb_d [2];
  logic [1:0]            pp_final_q, pp_final_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;

  logic                  pp_full, pp_empty;
  logic                  start_ok, accept, last_word, line_done, push, pop;
  logic [DATA_WIDTH-1:0] line_data;
  logic [STRB_WIDTH-1:0] line_strb;

  assign pp_full  = (wr_ptr_q[1] != rd_ptr_q[1]) && (wr_ptr_q[0] == rd_ptr_q[0]);
  assign pp_empty = (wr_ptr_q == rd_ptr_q);

  assign start_ok     = noc_rd_start && !busy_q;
  assign noc_rd_busy  = busy_q;
  assign noc_rd_ready = busy_q && !pp_full && (word_cnt_q < word_num_q);
  assign accept       = noc_rd_valid && noc_rd_ready;
  assign last_word    = (word_cnt_q == word_num_q - 13'd1);
  assign line_done    = (word_off_q == LAST_LANE) || last_word;
  assign push         = accept && line_done;
  assign len_err      = accept && (noc_rd_last != last_word);

  assign ibuffer_cen  = !pp_empty;
  assign ibuffer_wen  = ibuffer_cen;
  assign pop          = ibuffer_cen && ibuffer_ready;
  // Zero-length transfers finish without touching the ibuffer.
  assign noc_rd_done  = (pop && pp_final_q[rd_ptr_q[0]]) || zero_len_q;

  // Outputs are forced to zero while idle so nothing stale is presented.
  assign ibuffer_addr  = ibuffer_cen ? pp_addr_q[rd_ptr_q[0]] : '0;
  assign ibuffer_wdata = ibuffer_cen ? pp_data_q[rd_ptr_q[0]] : '0;
  assign ibuffer_wstrb = ibuffer_cen ? pp_strb_q[rd_ptr_q[0]] : '0;

  always_comb begin
    busy_d      = busy_q;
    zero_len_d  = zero_len_q;
    word_num_d  = word_num_q;
    word_cnt_d  = word_cnt_q;
    line_addr_d = line_addr_q;
    word_off_d  = word_off_q;
    asm_data_d  = asm_data_q;
    asm_strb_d  = asm_strb_q;
    pp_addr_d   = pp_addr_q;
    pp_data_d   = pp_data_q;
    pp_strb_d   = pp_strb_q;
    pp_final_d  = pp_final_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    // Line as it looks with the incoming word merged into its lane; this is
    // what gets pushed when the word closes the line, so the pingpong entry
    // is written on the same edge as the accept.
    line_data = asm_data_q;
    line_strb = asm_strb_q;
    for (int l = 0; l < WORD_NUM; l++) begin
      if (word_off_q == WOFF'(l)) begin
        line_data[l*WORD_WIDTH +: WORD_WIDTH] = noc_rd_data;
        line_strb[l*WSTRB +: WSTRB]           = '1;
      end
    end

    if (start_ok) begin
      busy_d      = 1'b1;
      zero_len_d  = (ibuffer_word_num == 13'd0);
      word_num_d  = ibuffer_word_num;
      word_cnt_d  = '0;
      line_addr_d = ibuffer_word_addr[WOFF +: MEM_AW];
      word_off_d  = ibuffer_word_addr[WOFF-1:0];
      asm_strb_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
    end

    if (accept) begin
      asm_data_d = line_data;
      asm_strb_d = line_done ? '0 : line_strb;
      word_off_d = word_off_q + 1'b1;
      word_cnt_d = word_cnt_q + 13'd1;
      if (line_done) begin
        line_addr_d = line_addr_q + 1'b1;
      end
    end

    if (push) begin
      pp_addr_d[wr_ptr_q[0]]  = line_addr_q;
      pp_data_d[wr_ptr_q[0]]  = line_data;
      pp_strb_d[wr_ptr_q[0]]  = line_strb;
      pp_final_d[wr_ptr_q[0]] = last_word;
      wr_ptr_d                = wr_ptr_q + 2'd1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end

    if (noc_rd_done) begin
      busy_d     = 1'b0;
      zero_len_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      zero_len_q  <= 1'b0;
      word_num_q  <= '0;
      word_cnt_q  <= '0;
      line_addr_q <= '0;
      word_off_q  <= '0;
      asm_data_q  <= '0;
      asm_strb_q  <= '0;
      pp_final_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        pp_addr_q[i] <= '0;
        pp_data_q[i] <= '0;
        pp_strb_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      zero_len_q  <= zero_len_d;
      word_num_q  <= word_num_d;
      word_cnt_q  <= word_cnt_d;
      line_addr_q <= line_addr_d;
      word_off_q  <= word_off_d;
      asm_data_q  <= asm_data_d;
      asm_strb_q  <= asm_strb_d;
      pp_final_q  <= pp_final_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      for (int i = 0; i < 2; i++) begin
        pp_addr_q[i] <= pp_addr_d[i];
        pp_data_q[i] <= pp_data_d[i];
        pp_strb_q[i] <= pp_strb_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ictrl_noc_to_ibuffer_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_ictrl_noc_to_ibuffer_write
// Purpose  : Randomized self-checking bench. Expected ibuffer lines are built
//            from absolute word addresses (line = addr/4, lane = addr%4); a
//            count of completed-but-unwritten lines predicts cen/ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ictrl_noc_to_ibuffer_write;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [16:0]  ibuffer_word_addr;
  logic [12:0]  ibuffer_word_num;
  logic         noc_rd_start;
  logic         noc_rd_done;
  logic         noc_rd_busy;
  logic         noc_rd_valid;
  logic         noc_rd_ready;
  logic [31:0]  noc_rd_data;
  logic         noc_rd_last;
  logic         len_err;
  logic         ibuffer_cen;
  logic         ibuffer_wen;
  logic         ibuffer_ready;
  logic [14:0]  ibuffer_addr;
  logic [127:0] ibuffer_wdata;
  logic [15:0]  ibuffer_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ictrl_noc_to_ibuffer_write dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ibuffer_word_addr (ibuffer_word_addr),
    .ibuffer_word_num  (ibuffer_word_num),
    .noc_rd_start      (noc_rd_start),
    .noc_rd_done       (noc_rd_done),
    .noc_rd_busy       (noc_rd_busy),
    .noc_rd_valid      (noc_rd_valid),
    .noc_rd_ready      (noc_rd_ready),
    .noc_rd_data       (noc_rd_data),
    .noc_rd_last       (noc_rd_last),
    .len_err           (len_err),
    .ibuffer_cen       (ibuffer_cen),
    .ibuffer_wen       (ibuffer_wen),
    .ibuffer_ready     (ibuffer_ready),
    .ibuffer_addr      (ibuffer_addr),
    .ibuffer_wdata     (ibuffer_wdata),
    .ibuffer_wstrb     (ibuffer_wstrb)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  noc_rd_busy,   0);
    chk({tag, "_done"},  noc_rd_done,   0);
    chk({tag, "_lerr"},  len_err,       0);
    chk({tag, "_rdy"},   noc_rd_ready,  0);
    chk({tag, "_cen"},   ibuffer_cen,   0);
    chk({tag, "_wen"},   ibuffer_wen,   0);
    chk({tag, "_addr"},  ibuffer_addr,  0);
    chk({tag, "_wdata"}, ibuffer_wdata, 0);
    chk({tag, "_wstrb"}, ibuffer_wstrb, 0);
  endtask

  // One transfer. stall: ibuffer_ready forced low for cycles <= stall.
  // early: extra word index on which the sender raises noc_rd_last (-1 none).
  // rst_at: assert reset once this many words have been accepted (-1 never).
  task automatic run(input logic [16:0] addr, input int num, input int vprob,
                     input int rprob, input int stall, input int early, input int rst_at);
    logic [31:0]  wd     [64];
    logic [14:0]  l_addr [64];
    logic [127:0] l_data [64];
    logic [15:0]  l_strb [64];
    bit           cmpl   [64];
    logic [16:0]  a;
    logic [127:0] m;
    int  nl, acc, p, w;
    bit  busy_m, first, e_cen, e_rdy, e_acc, e_hs, e_done;

    nl = 0;
    for (int i = 0; i < num; i++) begin
      wd[i] = $urandom;
      a = addr + 17'(i);
      if (i == 0 || a[1:0] == 2'd0) begin
        l_addr[nl] = a[16:2];
        l_data[nl] = '0;
        l_strb[nl] = '0;
        nl++;
      end
      l_data[nl-1][a[1:0]*32 +: 32] = wd[i];
      l_strb[nl-1][a[1:0]*4 +: 4]   = 4'hF;
      cmpl[i] = (a[1:0] == 2'd3) || (i == num - 1);
    end

    acc = 0; p = 0; w = 0; busy_m = 0; first = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      noc_rd_start = (cyc == 0) || (busy_m && $urandom_range(99) < 5);
      if (cyc == 0) begin
        ibuffer_word_addr = addr;
        ibuffer_word_num  = 13'(num);
      end else begin
        ibuffer_word_addr = 17'($urandom);
        ibuffer_word_num  = 13'($urandom_range(60));
      end
      noc_rd_valid  = (acc < num) && ($urandom_range(99) < vprob);
      noc_rd_data   = (acc < num) ? wd[acc] : $urandom;
      noc_rd_last   = (acc == num - 1) || (acc == early);
      ibuffer_ready = (cyc > stall) && ($urandom_range(99) < rprob);
      #1;
      e_cen  = (p > w);
      e_rdy  = busy_m && (p - w < 2) && (acc < num);
      e_acc  = noc_rd_valid && e_rdy;
      e_hs   = e_cen && ibuffer_ready;
      e_done = (e_hs && w == nl - 1) || (first && num == 0);

      chk("busy",    noc_rd_busy,  busy_m);
      chk("rd_ready", noc_rd_ready, e_rdy);
      chk("cen",     ibuffer_cen,  e_cen);
      chk("wen",     ibuffer_wen,  e_cen);
      chk("done",    noc_rd_done,  e_done);
      chk("len_err", len_err,      e_acc && (noc_rd_last != (acc == num - 1)));
      if (rprob == 100 && stall < 0 && busy_m && acc < num)
        chk("thruput", noc_rd_ready, 1);
      if (e_cen) begin
        for (int b = 0; b < 16; b++) m[b*8 +: 8] = {8{l_strb[w][b]}};
        chk("addr",  ibuffer_addr,      l_addr[w]);
        chk("wstrb", ibuffer_wstrb,     l_strb[w]);
        chk("wdata", ibuffer_wdata & m, l_data[w]);
      end

      if (e_acc) begin
        if (cmpl[acc]) p++;
        acc++;
      end
      if (e_hs) w++;
      if (cyc == 0) busy_m = 1;
      if (e_done) busy_m = 0;
      first = (cyc == 0);

      if (rst_at >= 0 && acc == rst_at) begin
        @(negedge clk);
        rst_n        = 1'b0;
        noc_rd_start = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        noc_rd_valid = 1'b0;
        rst_n        = 1'b1;
        return;
      end
      if (cyc > 0 && !busy_m) return;
    end
    chk("timeout", 1, 0);
  endtask

  initial begin
    rst_n             = 1'b0;
    ibuffer_word_addr = '0;
    ibuffer_word_num  = '0;
    noc_rd_start      = 1'b0;
    noc_rd_valid      = 1'b0;
    noc_rd_data       = '0;
    noc_rd_last       = 1'b0;
    ibuffer_ready     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    run(17'h00010,  8, 100, 100, -1, -1, -1);  // two full lines 0x4, 0x5
    run(17'h0000D,  5, 100, 100, -1, -1, -1);  // lane1 start: 0xFFF0 / 0x00FF
    run(17'h00020, 16, 100, 100, 10, -1, -1);  // ibuffer stalled, pingpong fills
    run(17'h00040,  0, 100, 100, -1, -1, -1);  // zero length
    run(17'h00030,  3, 100, 100, -1,  1, -1);  // early last on index 1
    run(17'h1FFFE,  4, 100, 100, -1, -1, -1);  // line address wraps
    run(17'h00050,  8, 100, 100, -1, -1,  2);  // reset mid-transfer
    run(17'h00060,  8, 100, 100, -1, -1, -1);  // clean transfer after reset

    for (int r = 0; r < 30; r++) begin
      int n;
      int e;
      n = $urandom_range(40);
      e = ($urandom_range(3) == 0) ? $urandom_range(40) : -1;
      run(17'($urandom), n, $urandom_range(100, 30), $urandom_range(100, 30),
          $urandom_range(6) - 1, e, -1);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
